rcomp_uart_rx_pro: RTL and testbench

RCOMP_UART_RX_PRO -- requirements
Module: rcomp_uart_rx_pro

---
 rtl/rcomp_uart_pkg.sv | 29 ++
 rtl/rcomp_uart_bit_sampler.sv | 69 ++++++
 rtl/rcomp_uart_rx_pro.sv | 217 +++++++++++++++++++++
 tb/tb_rcomp_uart_rx_pro.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/rcomp_uart_pkg.sv
// Shared definitions for the rcomp UART receiver: default line timing,
// the receiver FSM state encoding and a small majority-vote helper.
// Build option: RCOMP_UART_RX_PARITY_EN adds the PARITY state.
package rcomp_uart_pkg;

   localparam int DEF_CLK_FREQ = 50_000_000;
   localparam int DEF_UART_BPS = 115_200;

   // state     | meaning
   // ST_IDLE   | line idle, waiting for a synchronised 1->0 edge
   // ST_START  | inside the start bit, rejecting glitches
   // ST_DATA   | shifting in payload bits, LSB first
   // ST_PARITY | receiving the parity bit (parity builds only)
   // ST_STOP   | checking stop bit(s), then reporting the frame
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef RCOMP_UART_RX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } rx_state_e;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/rcomp_uart_bit_sampler.sv
// Bit-period timer and 3-sample majority voter for the UART receiver.
// The counter holds at zero while run is low, so every new frame begins
// its first bit period at count 0. Samples are taken at MID-1, MID and
// MID+1; the vote is presented during the MID+1 cycle together with
// sample_done. bit_end marks the last count of each bit period.
module rcomp_uart_bit_sampler
   import rcomp_uart_pkg::*;
#(
   parameter int BPS_CNT = DEF_CLK_FREQ / DEF_UART_BPS
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic rxd,
   output logic sample_done,
   output logic bit_end,
   output logic bit_val
);

   localparam int MID   = BPS_CNT / 2;
   localparam int CNT_W = $clog2(BPS_CNT);

   localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(MID - 1);
   localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(MID);
   localparam logic [CNT_W-1:0] CNT_S2   = CNT_W'(MID + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             smp0_q, smp0_d;
   logic             smp1_q, smp1_d;

   // next bit-period count and the two early samples of the vote
   always_comb begin
      cnt_d  = cnt_q;
      smp0_d = smp0_q;
      smp1_d = smp1_q;
      if (!run) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
      if (run && (cnt_q == CNT_S0)) begin
         smp0_d = rxd;
      end
      if (run && (cnt_q == CNT_S1)) begin
         smp1_d = rxd;
      end
   end

   // counter and sample registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         smp0_q <= 1'b1;
         smp1_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         smp0_q <= smp0_d;
         smp1_q <= smp1_d;
      end
   end

   assign sample_done = run && (cnt_q == CNT_S2);
   assign bit_end     = run && (cnt_q == CNT_LAST);
   assign bit_val     = maj3(smp0_q, smp1_q, rxd);

endmodule

// File: rtl/rcomp_uart_rx_pro.sv
// UART receiver: 2-flop synchroniser, start-edge detect, glitch-rejecting
// start bit, DATA_BITS payload LSB first, optional parity, 1 or 2 stop bits.
// A frame is reported one cycle after the last stop bit's final sample, so
// the FSM is back in IDLE half a bit early and back-to-back frames are kept.
// Build option: define RCOMP_UART_RX_PARITY_EN to receive one parity bit.
module rcomp_uart_rx_pro
   import rcomp_uart_pkg::*;
#(
   parameter int CLK_FREQ   = DEF_CLK_FREQ,
   parameter int UART_BPS   = DEF_UART_BPS,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 uart_rxd,
   output logic                 uart_done,
   output logic [DATA_BITS-1:0] uart_data,
   output logic                 frame_err,
   output logic                 parity_err
);

   localparam int BPS_CNT = CLK_FREQ / UART_BPS;
   localparam int IDX_W   = $clog2(DATA_BITS);

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
   localparam logic             LAST_STOP = (STOP_BITS == 2);

   // elaboration-time parameter sanity
   if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
      $error("rcomp_uart_rx_pro: DATA_BITS must be 5..9");
   end
   if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
      $error("rcomp_uart_rx_pro: STOP_BITS must be 1 or 2");
   end
   if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_parity_odd
      $error("rcomp_uart_rx_pro: PARITY_ODD must be 0 or 1");
   end

   logic rxd_s1_q, rxd_s2_q, rxd_s3_q;
   logic rx_fall;

   rx_state_e            state_q, state_d;
   logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
   logic                 stop_idx_q, stop_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 ferr_acc_q, ferr_acc_d;
   logic                 done_q, done_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 ferr_q, ferr_d;
   logic                 perr_q, perr_d;
`ifdef RCOMP_UART_RX_PARITY_EN
   logic                 par_bit_q, par_bit_d;
   localparam logic      PAR_ODD_BIT = (PARITY_ODD != 0);
`endif

   logic sample_done, bit_end, bit_val;
   logic run;

   // synchroniser plus one delayed copy for falling-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxd_s1_q <= 1'b1;
         rxd_s2_q <= 1'b1;
         rxd_s3_q <= 1'b1;
      end else begin
         rxd_s1_q <= uart_rxd;
         rxd_s2_q <= rxd_s1_q;
         rxd_s3_q <= rxd_s2_q;
      end
   end

   assign rx_fall = rxd_s3_q & ~rxd_s2_q;
   assign run     = (state_q != ST_IDLE);

   rcomp_uart_bit_sampler #(
      .BPS_CNT (BPS_CNT)
   ) u_sampler (
      .clk         (clk),
      .rst_n       (rst_n),
      .run         (run),
      .rxd         (rxd_s2_q),
      .sample_done (sample_done),
      .bit_end     (bit_end),
      .bit_val     (bit_val)
   );

   // receiver FSM and frame result capture
   always_comb begin
      state_d    = state_q;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      shift_d    = shift_q;
      ferr_acc_d = ferr_acc_q;
      done_d     = 1'b0;
      data_d     = data_q;
      ferr_d     = ferr_q;
      perr_d     = perr_q;
`ifdef RCOMP_UART_RX_PARITY_EN
      par_bit_d  = par_bit_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (rx_fall) begin
               state_d    = ST_START;
               bit_idx_d  = '0;
               stop_idx_d = 1'b0;
               ferr_acc_d = 1'b0;
            end
         end
         ST_START: begin
            if (sample_done && bit_val) begin
               state_d = ST_IDLE;
            end else if (bit_end) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (sample_done) begin
               for (int i = 0; i < DATA_BITS; i++) begin
                  if (bit_idx_q == IDX_W'(i)) begin
                     shift_d[i] = bit_val;
                  end
               end
            end
            if (bit_end) begin
               if (bit_idx_q == LAST_IDX) begin
                  bit_idx_d = '0;
`ifdef RCOMP_UART_RX_PARITY_EN
                  state_d   = ST_PARITY;
`else
                  state_d   = ST_STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end
         end
`ifdef RCOMP_UART_RX_PARITY_EN
         ST_PARITY: begin
            if (sample_done) begin
               par_bit_d = bit_val;
            end
            if (bit_end) begin
               state_d = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (sample_done) begin
               if (stop_idx_q == LAST_STOP) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                  data_d  = shift_q;
                  ferr_d  = ferr_acc_q | ~bit_val;
`ifdef RCOMP_UART_RX_PARITY_EN
                  perr_d  = ((^shift_q) ^ par_bit_q) != PAR_ODD_BIT;
`else
                  perr_d  = 1'b0;
`endif
               end else begin
                  ferr_acc_d = ferr_acc_q | ~bit_val;
               end
            end
            if (bit_end) begin
               stop_idx_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         shift_q    <= '0;
         ferr_acc_q <= 1'b0;
         done_q     <= 1'b0;
         data_q     <= '0;
         ferr_q     <= 1'b0;
         perr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         shift_q    <= shift_d;
         ferr_acc_q <= ferr_acc_d;
         done_q     <= done_d;
         data_q     <= data_d;
         ferr_q     <= ferr_d;
         perr_q     <= perr_d;
      end
   end

`ifdef RCOMP_UART_RX_PARITY_EN
   // received parity bit, held for the end-of-frame check
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_bit_q <= 1'b0;
      end else begin
         par_bit_q <= par_bit_d;
      end
   end
`endif

   assign uart_done  = done_q;
   assign uart_data  = data_q;
   assign frame_err  = ferr_q;
   assign parity_err = perr_q;

endmodule

// File: tb/tb_rcomp_uart_rx_pro.sv
// Directed bench for rcomp_uart_rx_pro at default timing (434 clocks/bit).
module tb_rcomp_uart_rx_pro;

   localparam int BPS = 434;

   logic       clk;
   logic       rst_n;
   logic       uart_rxd;
   logic       uart_done;
   logic [7:0] uart_data;
   logic       frame_err;
   logic       parity_err;

   int total = 0;
   int bad   = 0;

   int         pulse_cnt = 0;
   logic [7:0] log_data [0:15];
   logic       log_ferr [0:15];
   logic       log_perr [0:15];

   typedef struct {
      logic [7:0] data;
      logic       stop_val;
      logic       exp_ferr;
      logic       exp_perr;
   } vec_t;

   vec_t vecs [0:5];

   rcomp_uart_rx_pro dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .uart_rxd   (uart_rxd),
      .uart_done  (uart_done),
      .uart_data  (uart_data),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // log every done pulse with the values presented alongside it
   always @(negedge clk) begin
      if (uart_done) begin
         pulse_cnt = pulse_cnt + 1;
         log_data[pulse_cnt % 16] = uart_data;
         log_ferr[pulse_cnt % 16] = frame_err;
         log_perr[pulse_cnt % 16] = parity_err;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      uart_rxd = b;
      tick(BPS);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_val, input logic par);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef RCOMP_UART_RX_PARITY_EN
      send_bit(par);
`endif
      send_bit(stop_val);
      uart_rxd = 1'b1;
   endtask

   initial begin
      int base;

      vecs[0] = '{data: 8'hA5, stop_val: 1'b1, exp_ferr: 1'b0, exp_perr: 1'b0};
      vecs[1] = '{data: 8'h3C, stop_val: 1'b0, exp_ferr: 1'b1, exp_perr: 1'b0};
      vecs[2] = '{data: 8'h5A, stop_val: 1'b1, exp_ferr: 1'b0, exp_perr: 1'b0};
      vecs[3] = '{data: 8'h01, stop_val: 1'b1, exp_ferr: 1'b0, exp_perr: 1'b0};
      vecs[4] = '{data: 8'h80, stop_val: 1'b0, exp_ferr: 1'b1, exp_perr: 1'b0};
      vecs[5] = '{data: 8'hE7, stop_val: 1'b1, exp_ferr: 1'b0, exp_perr: 1'b0};

      uart_rxd = 1'b1;
      rst_n    = 1'b0;
      tick(5);
      check("rst_done",  32'(uart_done),  0);
      check("rst_data",  32'(uart_data),  0);
      check("rst_ferr",  32'(frame_err),  0);
      check("rst_perr",  32'(parity_err), 0);
      check("rst_state", 32'(dut.state_q), 0);
      rst_n = 1'b1;
      tick(50);

      // table of single frames, each followed by an idle gap
      for (int v = 0; v < 6; v++) begin
         base = pulse_cnt;
         send_frame(vecs[v].data, vecs[v].stop_val, ^vecs[v].data);
         tick(50);
         check($sformatf("vec%0d_pulses", v), 32'(pulse_cnt - base), 1);
         check($sformatf("vec%0d_data", v), 32'(log_data[pulse_cnt % 16]), 32'(vecs[v].data));
         check($sformatf("vec%0d_ferr", v), 32'(log_ferr[pulse_cnt % 16]), 32'(vecs[v].exp_ferr));
         check($sformatf("vec%0d_perr", v), 32'(log_perr[pulse_cnt % 16]), 32'(vecs[v].exp_perr));
         check($sformatf("vec%0d_hold", v), 32'(uart_data), 32'(vecs[v].data));
      end

      // back-to-back frames with no idle gap
      base = pulse_cnt;
      send_frame(8'h00, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0);
      tick(50);
      check("b2b_pulses", 32'(pulse_cnt - base), 2);
      check("b2b_first",  32'(log_data[(base + 1) % 16]), 32'h00);
      check("b2b_second", 32'(log_data[(base + 2) % 16]), 32'hFF);

      // 100-cycle low glitch on an idle line
      base = pulse_cnt;
      uart_rxd = 1'b0;
      tick(100);
      uart_rxd = 1'b1;
      tick(300);
      check("glitch_idle", 32'(dut.state_q), 0);
      tick(5000);
      check("glitch_pulses", 32'(pulse_cnt - base), 0);

      // line held low after a bad-stop frame must not start a new frame
      base = pulse_cnt;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(1'b1);
`ifdef RCOMP_UART_RX_PARITY_EN
      send_bit(1'b0);
`endif
      uart_rxd = 1'b0;
      tick(6 * BPS);
      check("low_hold_pulses", 32'(pulse_cnt - base), 1);
      check("low_hold_ferr",   32'(frame_err), 1);
      check("low_hold_state",  32'(dut.state_q), 0);
      uart_rxd = 1'b1;
      tick(100);

      // reset during data bit 4 of 0x55, then a clean 0x81
      base = pulse_cnt;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(i[0] ? 1'b0 : 1'b1);
      uart_rxd = 1'b1;
      tick(200);
      rst_n = 1'b0;
      tick(3);
      check("midrst_data",  32'(uart_data), 0);
      check("midrst_state", 32'(dut.state_q), 0);
      rst_n = 1'b1;
      tick(6 * BPS);
      check("midrst_nopulse", 32'(pulse_cnt - base), 0);
      send_frame(8'h81, 1'b1, 1'b0);
      tick(50);
      check("midrst_pulses", 32'(pulse_cnt - base), 1);
      check("midrst_data81", 32'(log_data[pulse_cnt % 16]), 32'h81);

`ifdef RCOMP_UART_RX_PARITY_EN
      // even parity: 0x07 has odd weight, so parity bit 0 is wrong
      base = pulse_cnt;
      send_frame(8'h07, 1'b1, 1'b0);
      tick(50);
      check("par_bad_pulses", 32'(pulse_cnt - base), 1);
      check("par_bad_perr",   32'(parity_err), 1);
      send_frame(8'h07, 1'b1, 1'b1);
      tick(50);
      check("par_ok_pulses", 32'(pulse_cnt - base), 2);
      check("par_ok_perr",   32'(parity_err), 0);
      check("par_ok_data",   32'(uart_data), 32'h07);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
